// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// default register-file address width and the hard-wired zero register.
package pipe_pkg;

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    localparam int ADDR_RFILE_DEF = 5;

    localparam logic [ADDR_RFILE_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load in
// EX has not yet produced. Writes to the zero register never create a hazard.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int AW = ADDR_RFILE_DEF
) (
    input  logic          ex_mem_to_rfile,
    input  logic [AW-1:0] ex_wb_addr,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    output logic          load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_uses_rs & (id_rs_addr == ex_wb_addr);
    assign rt_hit   = id_uses_rt & (id_rt_addr == ex_wb_addr);
    assign load_use = ex_mem_to_rfile & (ex_wb_addr != AW'(REG_ZERO)) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes and dmem wait states with a timeout. Optional macro LP_GATE_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_RFILE = ADDR_RFILE_DEF,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_RFILE-1:0] id_rs_addr,
    input  logic [ADDR_RFILE-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_to_rfile,
    input  logic [ADDR_RFILE-1:0] ex_wb_addr,
    input  logic                  br_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  stall_ctrl_t2,
    output logic                  flush_ctrl_t2,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

    logic              state;
    logic              state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_nxt;
    logic              err_set;
    logic              load_use;
    logic              mem_wait;
    logic              hold;

    hazard_detect #(.AW(ADDR_RFILE)) u_hazard_detect (
        .ex_mem_to_rfile (ex_mem_to_rfile),
        .ex_wb_addr      (ex_wb_addr),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .load_use        (load_use)
    );

    // A dropped request is treated exactly like a completed access.
    assign mem_wait = dmem_req & ~dmem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    // Watchdog expiry: flag the error and release as if ready.
                    err_set      = 1'b1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_ifid    = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        stall_ctrl_t2 = 1'b0;
        flush_ctrl_t2 = 1'b0;
        if (state == ST_RUN) begin
            hold = mem_wait;
        end else begin
            hold = mem_wait && (wait_cnt != WAIT_LIMIT);
        end
        // Memory wait outranks branch and load-use; ID/EX is held by stall_pc.
        if (hold) begin
            stall_pc      = 1'b1;
            stall_ifid    = 1'b1;
            stall_ctrl_t2 = 1'b1;
`ifdef LP_GATE_EN
            flush_ctrl_t2 = 1'b1;
`endif
        end else if (br_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
`ifdef LP_GATE_EN
            flush_ctrl_t2 = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with WAIT_MAX=4 and CNT_W=4 so
// the watchdog and counter saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
`ifdef LP_GATE_EN
    localparam logic LPG = 1'b1;
`else
    localparam logic LPG = 1'b0;
`endif
    // {stall_pc, stall_ifid, flush_ifid, flush_idex, stall_ctrl_t2, flush_ctrl_t2}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_BR   = 6'b001100;
    localparam logic [5:0] C_LU   = {5'b11010, LPG};
    localparam logic [5:0] C_MW   = {5'b11001, LPG};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs_addr, id_rt_addr, ex_wb_addr;
    logic          id_uses_rs, id_uses_rt, ex_mem_to_rfile;
    logic          br_taken, dmem_req, dmem_ready;
    logic          stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic          stall_ctrl_t2, flush_ctrl_t2, mem_err;
    logic [CW-1:0] stall_cnt;
    logic [5:0]    ctrl;

    int tests = 0;
    int fails = 0;

    pipe_hazard_ctrl #(.ADDR_RFILE(AW), .WAIT_MAX(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_to_rfile(ex_mem_to_rfile), .ex_wb_addr(ex_wb_addr),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .stall_ctrl_t2(stall_ctrl_t2), .flush_ctrl_t2(flush_ctrl_t2),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl = {stall_pc, stall_ifid, flush_ifid, flush_idex, stall_ctrl_t2, flush_ctrl_t2};

    task automatic idle();
        id_rs_addr = '0; id_rt_addr = '0; ex_wb_addr = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_to_rfile = 1'b0;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] addr);
        ex_mem_to_rfile = 1'b1; ex_wb_addr = addr;
        id_uses_rs = 1'b1; id_rs_addr = addr;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1; #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE); end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
        tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        set_load_use(5'd5); #1;
        tests++; if (ctrl !== C_LU) begin fails++; $display("FAIL lu_rs got=%b exp=%b", ctrl, C_LU); end
        step(); idle(); #1;
        tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL lu_after got=%b exp=%b", ctrl, C_NONE); end
        ex_mem_to_rfile = 1'b1; ex_wb_addr = 5'd7; id_uses_rt = 1'b1; id_rt_addr = 5'd7; #1;
        tests++; if (ctrl !== C_LU) begin fails++; $display("FAIL lu_rt got=%b exp=%b", ctrl, C_LU); end
        step(); idle();
        ex_mem_to_rfile = 1'b1; ex_wb_addr = 5'd9; id_rs_addr = 5'd9; id_uses_rs = 1'b0; #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL lu_unused got=%b exp=%b", ctrl, C_NONE); end
        tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_rt_cnt got=%0d exp=2", stall_cnt); end
        step(); idle();
    endtask

    task automatic test_load_r0();
        set_load_use(5'd0); #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL load_r0 got=%b exp=%b", ctrl, C_NONE); end
        step(); idle(); #1;
        tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL load_r0_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch_load_use();
        set_load_use(5'd3); br_taken = 1'b1; #1;
        tests++; if (ctrl !== C_BR) begin fails++; $display("FAIL br_lu got=%b exp=%b", ctrl, C_BR); end
        step(); idle(); #1;
        tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL br_lu_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        dmem_req = 1'b1; dmem_ready = 1'b0; br_taken = 1'b1; set_load_use(5'd4); #1;
        tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL mw_c1 got=%b exp=%b", ctrl, C_MW); end
        step(); br_taken = 1'b0; #1;
        tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL mw_c2 got=%b exp=%b", ctrl, C_MW); end
        step();
        tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL mw_c3 got=%b exp=%b", ctrl, C_MW); end
        step(); dmem_ready = 1'b1; #1;
        tests++; if (ctrl !== C_LU) begin fails++; $display("FAIL mw_release got=%b exp=%b", ctrl, C_LU); end
        step(); idle(); #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL mw_idle got=%b exp=%b", ctrl, C_NONE); end
        tests++; if (stall_cnt !== 4'd6) begin fails++; $display("FAIL mw_cnt got=%0d exp=6", stall_cnt); end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL mw_err got=%b exp=0", mem_err); end
    endtask

    task automatic test_req_drop();
        dmem_req = 1'b1; #1;
        tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL drop_wait got=%b exp=%b", ctrl, C_MW); end
        step(); dmem_req = 1'b0; #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL drop_release got=%b exp=%b", ctrl, C_NONE); end
        step(); #1;
        tests++; if (stall_cnt !== 4'd7) begin fails++; $display("FAIL drop_cnt got=%0d exp=7", stall_cnt); end
    endtask

    task automatic test_timeout();
        dmem_req = 1'b1; dmem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL to_stall%0d got=%b exp=%b", i, ctrl, C_MW); end
            tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL to_early_err%0d got=%b exp=0", i, mem_err); end
            step();
        end
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL to_release got=%b exp=%b", ctrl, C_NONE); end
        step(); dmem_req = 1'b0; #1;
        tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL to_err got=%b exp=1", mem_err); end
        tests++; if (stall_cnt !== 4'd11) begin fails++; $display("FAIL to_cnt got=%0d exp=11", stall_cnt); end
        step(); step();
        tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        dmem_req = 1'b1; dmem_ready = 1'b0; step(); #1;
        tests++; if (ctrl !== C_MW) begin fails++; $display("FAIL rmw_wait got=%b exp=%b", ctrl, C_MW); end
        rst_n = 1'b0; step();
        rst_n = 1'b1; dmem_req = 1'b0; #1;
        tests++; if (ctrl !== C_NONE) begin fails++; $display("FAIL rmw_ctrl got=%b exp=%b", ctrl, C_NONE); end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rmw_err got=%b exp=0", mem_err); end
        tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL rmw_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_saturate();
        set_load_use(5'd12);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15 || i == 16 || i == 20) begin
                tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_c%0d got=%0d exp=15", i, stall_cnt); end
            end
        end
        idle(); step();
        tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
    endtask

    initial begin
        idle(); rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch_load_use();
        test_mem_wait();
        test_req_drop();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
